// File: rtl/dual_issue_scheduler.sv
// Issue stage of the two-issue core. Each cycle it decides which instructions of the fetched
// pair go to pipe0 (always the older one) and pipe1. A pair is split on an intra-pair RAW
// dependency, on two memory ops, on a control-flow op in slot0, or when slot1 reads a pending
// load result. The younger half of a split pair is held and issued alone on a later cycle. A
// single bubble is inserted on load-use. Issue outputs are registered and feed ID/EX.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid, in1_valid       pair present / slot1 holds a valid instruction
//   in0_* / in1_*             decoded source/dest regs, hazard flags, opaque payload
//   stall, flush              downstream freeze / redirect (flush wins)
//   in_ready                  pair consumed this cycle (combinational)
//   iss0_*, iss1_*            registered pipe0/pipe1 valid and payload
module dual_issue_scheduler #(
    parameter int unsigned PW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in1_valid,
    input  logic [4:0]    in0_rs1,
    input  logic [4:0]    in0_rs2,
    input  logic [4:0]    in0_rd,
    input  logic          in0_reg_write,
    input  logic          in0_mem,
    input  logic          in0_load,
    input  logic          in0_ctrl,
    input  logic [PW-1:0] in0_payload,
    input  logic [4:0]    in1_rs1,
    input  logic [4:0]    in1_rs2,
    input  logic [4:0]    in1_rd,
    input  logic          in1_reg_write,
    input  logic          in1_mem,
    input  logic          in1_load,
    input  logic          in1_ctrl,
    input  logic [PW-1:0] in1_payload,
    input  logic          stall,
    input  logic          flush,
    output logic          in_ready,
    output logic          iss0_valid,
    output logic          iss1_valid,
    output logic [PW-1:0] iss0_payload,
    output logic [PW-1:0] iss1_payload
);

    typedef enum logic {StEmpty, StHeld} state_e;

    state_e        state_q, state_d;
    logic [4:0]    held_rs1_q, held_rs2_q, held_rd_q;
    logic          held_load_q;
    logic [PW-1:0] held_payload_q;
    logic [4:0]    lu_rd_q, lu_rd_d;

    logic lu_in0, lu_held, lu_in1, dep, str, ctl, split;
    logic issue0, issue0_held, issue1, capture_held;
    logic load0;
    logic [4:0] rd0;

    // Slot1's register use and control flag never matter once it issues alone or as pipe1.
    logic unused_in1;
    assign unused_in1 = ^{in1_reg_write, in1_ctrl};

    // Hazard detection; register 0 never creates a hazard.
    assign lu_in0  = (lu_rd_q != 5'd0) && (in0_rs1 == lu_rd_q || in0_rs2 == lu_rd_q);
    assign lu_held = (lu_rd_q != 5'd0) && (held_rs1_q == lu_rd_q || held_rs2_q == lu_rd_q);
    assign lu_in1  = (lu_rd_q != 5'd0) && (in1_rs1 == lu_rd_q || in1_rs2 == lu_rd_q);
    assign dep     = in0_reg_write && (in0_rd != 5'd0) &&
                     (in1_rs1 == in0_rd || in1_rs2 == in0_rd);
    assign str     = in0_mem && in1_mem;
    assign ctl     = in0_ctrl;
    assign split   = dep || str || ctl || lu_in1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
        end else if (flush) begin
            state_q <= StEmpty;
        end else if (!stall) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (capture_held) state_d = StHeld;
            StHeld:  if (issue0)       state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // Issue decisions for this cycle; all zero while stalled or flushing.
    always_comb begin
        in_ready     = 1'b0;
        issue0       = 1'b0;
        issue0_held  = 1'b0;
        issue1       = 1'b0;
        capture_held = 1'b0;
        if (!flush && !stall) begin
            unique case (state_q)
                StEmpty: begin
                    if (in_valid && !lu_in0) begin
                        in_ready = 1'b1;
                        issue0   = 1'b1;
                        if (in1_valid) begin
                            if (split) capture_held = 1'b1;
                            else       issue1       = 1'b1;
                        end
                    end
                end
                StHeld: begin
                    if (!lu_held) begin
                        issue0      = 1'b1;
                        issue0_held = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Track the destination of a load issued this edge; at most one load can issue per cycle.
    always_comb begin
        load0   = issue0_held ? held_load_q : in0_load;
        rd0     = issue0_held ? held_rd_q   : in0_rd;
        lu_rd_d = 5'd0;
        if (issue0 && load0) begin
            lu_rd_d = rd0;
        end else if (issue1 && in1_load) begin
            lu_rd_d = in1_rd;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss0_valid     <= 1'b0;
            iss1_valid     <= 1'b0;
            iss0_payload   <= '0;
            iss1_payload   <= '0;
            held_rs1_q     <= 5'd0;
            held_rs2_q     <= 5'd0;
            held_rd_q      <= 5'd0;
            held_load_q    <= 1'b0;
            held_payload_q <= '0;
            lu_rd_q        <= 5'd0;
        end else if (flush) begin
            iss0_valid <= 1'b0;
            iss1_valid <= 1'b0;
            lu_rd_q    <= 5'd0;
        end else if (!stall) begin
            iss0_valid <= issue0;
            iss1_valid <= issue1;
            lu_rd_q    <= lu_rd_d;
            if (issue0) iss0_payload <= issue0_held ? held_payload_q : in0_payload;
            if (issue1) iss1_payload <= in1_payload;
            if (capture_held) begin
                held_rs1_q     <= in1_rs1;
                held_rs2_q     <= in1_rs2;
                held_rd_q      <= in1_rd;
                held_load_q    <= in1_load;
                held_payload_q <= in1_payload;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
module tb_dual_issue_scheduler;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mem;
        logic        load;
        logic        ctrl;
        logic [31:0] pl;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic   in_valid = 1'b0, in1_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    instr_t ia = '0, ib = '0;
    logic   in_ready, iss0_valid, iss1_valid;
    logic [31:0] iss0_payload, iss1_payload;

    dual_issue_scheduler #(.PW(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in1_valid(in1_valid),
        .in0_rs1(ia.rs1), .in0_rs2(ia.rs2), .in0_rd(ia.rd), .in0_reg_write(ia.rw),
        .in0_mem(ia.mem), .in0_load(ia.load), .in0_ctrl(ia.ctrl), .in0_payload(ia.pl),
        .in1_rs1(ib.rs1), .in1_rs2(ib.rs2), .in1_rd(ib.rd), .in1_reg_write(ib.rw),
        .in1_mem(ib.mem), .in1_load(ib.load), .in1_ctrl(ib.ctrl), .in1_payload(ib.pl),
        .stall(stall), .flush(flush), .in_ready(in_ready),
        .iss0_valid(iss0_valid), .iss1_valid(iss1_valid),
        .iss0_payload(iss0_payload), .iss1_payload(iss1_payload)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state: held instruction, pending load dest, expected outputs.
    bit          m_hv = 0;
    instr_t      m_h = '0;
    logic [4:0]  m_lu = 0;
    bit          e_v0 = 0, e_v1 = 0, e_ready = 0;
    logic [31:0] e_p0 = 0, e_p1 = 0;
    bit          n_hv, n_v0, n_v1;
    instr_t      n_h;
    logic [4:0]  n_lu;
    logic [31:0] n_p0, n_p1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit reads(input instr_t x, input logic [4:0] r);
        return (r != 0) && (x.rs1 == r || x.rs2 == r);
    endfunction

    function automatic instr_t mk(input int rs1, input int rs2, input int rd, input bit rw,
                                  input bit mem, input bit load, input bit ctrl,
                                  input logic [31:0] pl);
        instr_t x;
        x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.rd = 5'(rd);
        x.rw = rw; x.mem = mem; x.load = load; x.ctrl = ctrl; x.pl = pl;
        return x;
    endfunction

    // Builds the list of instructions leaving this cycle, oldest first.
    task automatic model_eval();
        instr_t q[$];
        bit do_split;
        n_hv = m_hv; n_h = m_h; n_lu = m_lu;
        n_v0 = e_v0; n_v1 = e_v1; n_p0 = e_p0; n_p1 = e_p1;
        e_ready = 0;
        if (flush) begin
            n_hv = 0; n_lu = 0; n_v0 = 0; n_v1 = 0;
        end else if (!stall) begin
            if (m_hv) begin
                if (!reads(m_h, m_lu)) begin
                    q.push_back(m_h);
                    n_hv = 0;
                end
            end else if (in_valid && !reads(ia, m_lu)) begin
                e_ready = 1;
                q.push_back(ia);
                if (in1_valid) begin
                    do_split = (ia.rw && reads(ib, ia.rd)) || (ia.mem && ib.mem) ||
                               ia.ctrl || reads(ib, m_lu);
                    if (do_split) begin
                        n_hv = 1;
                        n_h  = ib;
                    end else begin
                        q.push_back(ib);
                    end
                end
            end
            n_v0 = q.size() > 0;
            n_v1 = q.size() > 1;
            if (n_v0) n_p0 = q[0].pl;
            if (n_v1) n_p1 = q[1].pl;
            n_lu = 0;
            foreach (q[i]) if (q[i].load && n_lu == 0) n_lu = q[i].rd;
        end
    endtask

    // One clock: check in_ready before the edge, registered outputs just after it.
    task automatic cycle();
        #1;
        model_eval();
        chk("in_ready", {31'd0, in_ready}, {31'd0, e_ready});
        @(posedge clk);
        #1;
        m_hv = n_hv; m_h = n_h; m_lu = n_lu;
        e_v0 = n_v0; e_v1 = n_v1; e_p0 = n_p0; e_p1 = n_p1;
        chk("iss0_valid", {31'd0, iss0_valid}, {31'd0, e_v0});
        chk("iss1_valid", {31'd0, iss1_valid}, {31'd0, e_v1});
        if (e_v0) chk("iss0_payload", iss0_payload, e_p0);
        if (e_v1) chk("iss1_payload", iss1_payload, e_p1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_hv = 0; m_h = '0; m_lu = 0; e_v0 = 0; e_v1 = 0; e_p0 = 0; e_p1 = 0;
        chk("rst_iss0_valid", {31'd0, iss0_valid}, 32'd0);
        chk("rst_iss1_valid", {31'd0, iss1_valid}, 32'd0);
        chk("rst_iss0_payload", iss0_payload, 32'd0);
        chk("rst_iss1_payload", iss1_payload, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", {30'd0, iss0_valid, iss1_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic lit(input string name, input bit v0, input logic [31:0] p0, input bit v1,
                       input logic [31:0] p1);
        chk({name, "_v0"}, {31'd0, iss0_valid}, {31'd0, v0});
        chk({name, "_v1"}, {31'd0, iss1_valid}, {31'd0, v1});
        if (v0) chk({name, "_p0"}, iss0_payload, p0);
        if (v1) chk({name, "_p1"}, iss1_payload, p1);
    endtask

    task automatic lit_ready(input string name, input bit r);
        #1;
        chk(name, {31'd0, in_ready}, {31'd0, r});
    endtask

    function automatic instr_t rnd_instr();
        instr_t x;
        x.rs1  = 5'($urandom_range(0, 7));
        x.rs2  = 5'($urandom_range(0, 7));
        x.rd   = 5'($urandom_range(0, 7));
        x.mem  = ($urandom_range(0, 9) < 3);
        x.load = x.mem && $urandom_range(0, 1) == 1;
        x.rw   = x.load || $urandom_range(0, 3) != 0;
        x.ctrl = !x.mem && $urandom_range(0, 9) == 0;
        x.pl   = $urandom;
        if (!x.rw) x.rd = 0;
        return x;
    endfunction

    initial begin
        @(negedge clk);
        do_reset();

        // Independent pair dual-issues.
        ia = mk(0, 0, 1, 1, 0, 0, 0, 32'hA0); ib = mk(0, 0, 2, 1, 0, 0, 0, 32'hA1);
        in_valid = 1; in1_valid = 1;
        lit_ready("t1_ready", 1);
        cycle(); lit("t1", 1, 32'hA0, 1, 32'hA1);

        // RAW inside the pair splits; a held instruction never pairs with the next fetch.
        ia = mk(1, 2, 3, 1, 0, 0, 0, 32'hB0); ib = mk(3, 1, 4, 1, 0, 0, 0, 32'hB1);
        cycle(); lit("t2a", 1, 32'hB0, 0, 0);
        ia = mk(0, 0, 8, 1, 0, 0, 0, 32'hB2); ib = mk(0, 0, 9, 1, 0, 0, 0, 32'hB3);
        lit_ready("t2_held_ready", 0);
        cycle(); lit("t2b", 1, 32'hB1, 0, 0);
        cycle(); lit("t2c", 1, 32'hB2, 1, 32'hB3);

        // lw/sw splits on memory; the held store is not a load so lu_rd clears.
        ia = mk(1, 0, 5, 1, 1, 1, 0, 32'hC0); ib = mk(2, 6, 0, 0, 1, 0, 0, 32'hC1);
        cycle(); lit("t3a", 1, 32'hC0, 0, 0);
        ia = mk(5, 0, 7, 1, 0, 0, 0, 32'hC2); in1_valid = 0;
        cycle(); lit("t3b", 1, 32'hC1, 0, 0);
        cycle(); lit("t3c", 1, 32'hC2, 0, 0);

        // Held reader of a just-issued load waits one bubble.
        ia = mk(1, 0, 5, 1, 1, 1, 0, 32'hD0); ib = mk(5, 1, 7, 1, 0, 0, 0, 32'hD1);
        in1_valid = 1;
        cycle(); lit("t3d", 1, 32'hD0, 0, 0);
        in_valid = 0;
        cycle(); lit("t3e_bubble", 0, 0, 0, 0);
        cycle(); lit("t3f", 1, 32'hD1, 0, 0);

        // Branch in slot0 splits; flush drops the held add.
        ia = mk(1, 2, 0, 0, 0, 0, 1, 32'hE0); ib = mk(0, 0, 3, 1, 0, 0, 0, 32'hE1);
        in_valid = 1;
        cycle(); lit("t4a", 1, 32'hE0, 0, 0);
        flush = 1;
        ia = mk(0, 0, 1, 1, 0, 0, 0, 32'hE2); ib = mk(0, 0, 2, 1, 0, 0, 0, 32'hE3);
        lit_ready("t4_flush_ready", 0);
        cycle(); lit("t4b", 0, 0, 0, 0);
        flush = 0;
        cycle(); lit("t4c", 1, 32'hE2, 1, 32'hE3);

        // Stall while held freezes everything.
        ia = mk(1, 2, 3, 1, 0, 0, 0, 32'hF0); ib = mk(3, 0, 4, 1, 0, 0, 0, 32'hF1);
        cycle(); lit("t5a", 1, 32'hF0, 0, 0);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            lit_ready("t5_stall_ready", 0);
            cycle(); lit("t5_stall", 1, 32'hF0, 0, 0);
        end
        stall = 0; in_valid = 0;
        cycle(); lit("t5b", 1, 32'hF1, 0, 0);

        // Reset while held with a load in flight; reader of x5 then issues at once.
        ia = mk(1, 0, 5, 1, 1, 1, 0, 32'h100); ib = mk(5, 0, 7, 1, 0, 0, 0, 32'h101);
        in_valid = 1;
        cycle(); lit("t6a", 1, 32'h100, 0, 0);
        in_valid = 0;
        do_reset();
        ia = mk(5, 0, 6, 1, 0, 0, 0, 32'h102); ib = mk(0, 0, 7, 1, 0, 0, 0, 32'h103);
        in_valid = 1;
        lit_ready("t6_ready", 1);
        cycle(); lit("t6b", 1, 32'h102, 1, 32'h103);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            ia        = rnd_instr();
            ib        = rnd_instr();
            in_valid  = $urandom_range(0, 9) < 8;
            in1_valid = $urandom_range(0, 3) != 0;
            stall     = $urandom_range(0, 99) < 15;
            flush     = $urandom_range(0, 99) < 5;
            if ($urandom_range(0, 99) == 0) begin
                stall = 0; flush = 0;
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
